// File: rtl/wb_gpio_irq_if.sv
// Wishbone slave bundle for wb_gpio_irq: handshake, address, byte selects and data.
interface wb_gpio_irq_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// WIDTH-bit Wishbone GPIO with synchronised inputs, per-bit edge interrupts and W1C status.
// Optional per-bit input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio_irq #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  wb_gpio_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             intr
);

  localparam logic [7:0] A_CFG    = 8'h00;
  localparam logic [7:0] A_IN     = 8'h10;
  localparam logic [7:0] A_OUT    = 8'h14;
  localparam logic [7:0] A_OE     = 8'h18;
  localparam logic [7:0] A_MASK   = 8'h1C;
  localparam logic [7:0] A_POL    = 8'h20;
  localparam logic [7:0] A_BOTH   = 8'h24;
  localparam logic [7:0] A_STATUS = 8'h28;
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_arm_cnt;
  logic [WIDTH-1:0] r_out, r_oe, r_mask, r_pol, r_both, r_status;
  logic             r_ack, r_intr;
  logic [31:0]      r_dat;

  logic [WIDTH-1:0] w_sync, w_in_f, w_rise, w_fall, w_evt;
  logic [WIDTH-1:0] w_bmask, w_wdat, w_clr;
  logic [31:0]      w_lane, w_rdata;
  logic [7:0]       w_adr;
  logic             w_req, w_wr, w_rd, w_armed;
  logic             w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_in_f;

  // A bit follows the synchroniser only after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_f <= '0;
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] != r_in_f[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_in_f[i]   <= w_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_in_f = r_in_f;
`else
  assign w_in_f = w_sync;
`endif

  // Edges are ignored until the sync chain has flushed the post-reset pin state.
  assign w_armed = (r_arm_cnt == ARM_DONE);
  assign w_rise  = w_in_f & ~r_prev;
  assign w_fall  = ~w_in_f & r_prev;
  assign w_evt   = w_armed ? ((r_both & (w_rise | w_fall)) |
                              (~r_both & ((r_pol & w_rise) | (~r_pol & w_fall)))) : '0;

  assign w_adr   = wb.wb_adr_i[7:0];
  assign w_req   = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_wr    = w_req & wb.wb_we_i;
  assign w_rd    = w_req & ~wb.wb_we_i;
  assign w_lane  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                    {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign w_bmask = w_lane[WIDTH-1:0];
  assign w_wdat  = wb.wb_dat_i[WIDTH-1:0];
  assign w_clr   = (w_wr && w_adr == A_STATUS) ? (w_wdat & w_bmask) : '0;
  assign w_unused = ^{wb.wb_adr_i[31:8], wb.wb_dat_i, w_lane};

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      A_CFG:    w_rdata = {24'b0, 8'(WIDTH)};
      A_IN:     w_rdata = 32'(w_in_f);
      A_OUT:    w_rdata = 32'(r_out);
      A_OE:     w_rdata = 32'(r_oe);
      A_MASK:   w_rdata = 32'(r_mask);
      A_POL:    w_rdata = 32'(r_pol);
      A_BOTH:   w_rdata = 32'(r_both);
      A_STATUS: w_rdata = 32'(r_status);
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_arm_cnt <= '0;
      r_status  <= '0;
      r_intr    <= 1'b0;
    end else begin
      r_prev <= w_in_f;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
      // A same-cycle event beats the W1C clear.
      r_status <= (r_status & ~w_clr) | w_evt;
      r_intr   <= |(r_status & r_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_out  <= '0;
      r_oe   <= '0;
      r_mask <= '0;
      r_pol  <= '0;
      r_both <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd) r_dat <= w_rdata;
      if (w_wr) begin
        case (w_adr)
          A_OUT:   r_out  <= (r_out  & ~w_bmask) | (w_wdat & w_bmask);
          A_OE:    r_oe   <= (r_oe   & ~w_bmask) | (w_wdat & w_bmask);
          A_MASK:  r_mask <= (r_mask & ~w_bmask) | (w_wdat & w_bmask);
          A_POL:   r_pol  <= (r_pol  & ~w_bmask) | (w_wdat & w_bmask);
          A_BOTH:  r_both <= (r_both & ~w_bmask) | (w_wdat & w_bmask);
          default: ;
        endcase
      end
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & r_ack;
  assign wb.wb_dat_o = r_dat;
  assign gpio_out    = r_out;
  assign gpio_oe     = r_oe;
  assign intr        = r_intr;

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Parametrised successor to the existing Wishbone GPIO block: WIDTH-bit GPIO with synchronised inputs, per-bit edge-detect interrupts, a write-1-to-clear status register, and byte-select support on writes.
- Wishbone slave on the SoC peripheral bus.
- Drives one level interrupt `intr` to the CPU interrupt controller.

Parameters:
- WIDTH, 32, number of GPIO bits (1..32); register bits at WIDTH and above read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages on gpio_in before any use (2..4).
- DEBOUNCE_CYCLES, 16, stable-cycle count required by the debounce filter (used only with GPIO_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_ack_o  out  1  Wishbone acknowledge.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [7:0] decoded.
- wb_sel_i  in  4  byte enables for writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- intr  out  1  OR of (irq_status & irq_mask), registered.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  output values.
- gpio_oe  out  WIDTH  output enables, 1 = drive.

Behaviour:
- Reset (async, active-high):
  - gpio_out, gpio_oe, all irq registers, wb_dat_o, ack, intr = 0.
  - Synchroniser chain, the edge-detect previous-value register and the arm counter = 0.
- Register map (wb_adr_i[7:0]):
  - 0x00 CFG (RO) = {24'b0, WIDTH[7:0]}.
  - 0x10 IN (RO) = filtered synchronised input.
  - 0x14 OUT (RW).
  - 0x18 OE (RW).
  - 0x1C IRQ_MASK (RW).
  - 0x20 IRQ_POL (RW): 1 = rising edge, 0 = falling edge.
  - 0x24 IRQ_BOTH (RW): 1 = both edges, overrides POL.
  - 0x28 IRQ_STATUS (R/W1C).
  - Other addresses read 0; writes to them and to RO registers are ignored.
- Handshake:
  - Internal ack register sets for one cycle when stb & cyc & ~ack; wb_ack_o = stb & cyc & ack.
  - Every access has exactly 1 wait state, so ack is asserted in the 2nd cycle of the request.
  - wb_dat_o is loaded in the same edge that sets ack, and holds until the next read.
  - If stb is dropped before ack, the access is aborted: wb_ack_o goes low, and a write already taken on that edge stays committed.
- Writes: byte lane k of wb_dat_i is applied only if wb_sel_i[k] = 1. IRQ_STATUS clears only the bits that are 1 in the enabled lanes.
- Input path:
  - gpio_in passes through SYNC_STAGES flops, then the optional filter, giving `in_f`.
  - prev <= in_f every cycle.
  - rise = in_f & ~prev; fall = ~in_f & prev.
- Edge qualification per bit: evt = BOTH ? (rise | fall) : (POL ? rise : fall).
- Status update: status <= (status & ~w1c_clear) | evt.
  - Event and W1C on the same bit in the same cycle: the set wins, so the bit reads 1.
  - Status bits set regardless of mask; the mask gates only intr.
- Arm counter: edge detection is suppressed until SYNC_STAGES+1 cycles after reset release, so no spurious edges come from the reset-to-pin transition.
- intr <= |(status & mask); intr rises 1 cycle after a status bit is set with its mask bit at 1.
- Pin-to-status latency: SYNC_STAGES+1 cycles without filter.
- Reset asserted mid-transfer: ack drops asynchronously and the transfer is lost. The master must restart it.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - in_f[i] updates to the synchronised value only after that value has differed from in_f[i] for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the in_f value resets the counter.
  - Counters reset to 0.
- Undefined: in_f = synchroniser output; no counters are synthesised.

Test Plan:
- Reset, then read 0x00 with WIDTH=32 -> 0x00000020; read 0x14 -> 0; ack exactly 1 cycle after request; intr = 0.
- Write 0x14 = 0xA5A5A5A5 with sel = 4'b0011 -> read back 0x0000A5A5; gpio_out = 0x0000A5A5.
- MASK = 0x1, POL = 0x1; drive gpio_in[0] 0->1 -> STATUS = 0x1 after SYNC_STAGES+1 cycles; intr = 1 one cycle later. Write 1 to 0x28 -> STATUS = 0, intr = 0.
- BOTH = 0x2; pulse gpio_in[1] high for 10 cycles -> status bit 1 set on both edges. Issue W1C in the same cycle as the falling event -> bit remains 1.
- Hold gpio_in = 0xFFFFFFFF through reset release -> STATUS stays 0, no intr.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch on bit 3 -> IN bit 3 and STATUS unchanged. A 20-cycle level -> IN updates after 16 stable cycles plus sync latency.
